alu_op_sequencer: RTL
=====================

// Module: alu_op_sequencer
// PURPOSE
//  Operand/opcode loading controller in front of the 4-bit combinational ALU.
//  Captures A, B and opcode from board switches on button presses, in any order.
//  Once all three are held and the opcode is legal, it launches one evaluation
//  and registers the ALU result onto the LEDs.
//  Sits between the board I/O (switches, buttons, LEDs) and the ALU instance.
// PARAMETERS
//  NB_DATA       4        operand / result width
//  NB_OP         6        opcode width
//  NB_SW         8        switch bus width; must be >= max(NB_DATA, NB_OP)
//  DEBOUNCE_CYC  1000000  stable cycles required per button (only with BTN_DEBOUNCE_EN)
// PORTS
//  clk           in   1        system clock
//  i_rst_n       in   1        asynchronous active-low reset
//  i_sw          in   NB_SW    switch values, asynchronous to clk
//  i_btn_a       in   1        load A from i_sw[NB_DATA-1:0]; asynchronous
//  i_btn_b       in   1        load B from i_sw[NB_DATA-1:0]; asynchronous
//  i_btn_op      in   1        load opcode from i_sw[NB_OP-1:0]; asynchronous
//  o_datoA       out  NB_DATA  operand A to ALU (registered)
//  o_datoB       out  NB_DATA  operand B to ALU (registered)
//  o_operation   out  NB_OP    opcode to ALU (registered)
//  i_alu_result  in   NB_DATA  ALU combinational result
//  o_leds        out  NB_DATA  registered result
//  o_valid       out  1        high while o_leds holds a fresh result
//  o_err         out  1        1-cycle pulse: illegal opcode rejected
// BEHAVIOUR
//  - Reset (async assert, sync release): all outputs 0, load mask 3'b000, state IDLE.
//  - Each button: 2-FF synchronizer, then rising-edge detect -> 1-cycle press pulse.
//    i_sw is sampled through a 2-FF synchronizer in the same cycle as the pulse.
//  - Simultaneous pulses: priority A > B > OP. Lower-priority pulses that cycle are dropped, not queued.
//  - Legal opcodes: ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110,
//    SRA 000011, SRL 000010, NOR 100111. Illegal op press: o_err pulse; opcode reg and mask unchanged.
//  - FSM:
//    IDLE: mask==0. Any accepted press loads its field, sets its mask bit -> COLLECT.
//    COLLECT: accepted press loads/overwrites its field and sets its mask bit.
//      Mask becomes 3'b111 -> EXEC on the next cycle.
//    EXEC: exactly 1 cycle; button pulses ignored; operands stable.
//      o_leds <= i_alu_result at end of cycle -> SHOW.
//    SHOW: o_valid=1, o_leds held.
//      Accepted press clears o_valid, clears mask, loads that field with its bit set -> COLLECT.
//      Illegal op press here: o_err pulse, stays SHOW.
//  - Latency: last load press pulse -> o_leds/o_valid update = 2 clk.
//  - Overwriting a loaded field in COLLECT is allowed: last value wins.
//  - o_leds is never updated outside EXEC; o_valid is 0 in IDLE/COLLECT/EXEC.
// CONFIGURATION
//  BTN_DEBOUNCE_EN defined: a button pulse fires only after the synchronized
//    level is stable high for DEBOUNCE_CYC cycles (saturating counter per button).
//    Pulse latency becomes DEBOUNCE_CYC+3 cycles.
//  Undefined: no counter; pulse fires 3 cycles after the async edge.
//    DEBOUNCE_CYC is ignored.
// STRUCTURE
//  Package alu_pkg: opcode localparams (shared with the ALU), FSM state encoding,
//    is_legal_op function.
//  Sub-module btn_cond (x3): synchronizer + optional debounce + rising-edge pulse.
//  Top: switch synchronizer, load registers, mask, FSM, result register.
// TESTING
//  1 A=5, B=3, op=100000 presses -> EXEC, then o_leds=4'h8, o_valid=1 two cycles after op pulse.
//  2 Order op(SUB), B=5, A=3 -> o_leds=4'hE; order of loads does not matter.
//  3 op=111111 press in COLLECT -> o_err 1-cycle pulse, mask bit 2 stays 0, no EXEC.
//  4 Press A and B in the same cycle (A=2, B=7) -> only A loaded; mask=001.
//  5 Reset asserted mid-EXEC -> o_leds=0, o_valid=0, state IDLE, without waiting for a clk edge.
//  6 After a valid result, press B=1 -> o_valid drops, mask=010.
//    Then A=6, op NOR -> o_leds=4'h8.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, sequencer FSM states and opcode legality check.
package alu_pkg;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_EXEC    = 2'd2,
    ST_SHOW    = 2'd3
  } state_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, OP_NOR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_sequencer_btn_cond.sv
// Button conditioner: 2-FF synchronizer, optional debounce (BTN_DEBOUNCE_EN), rising-edge pulse.
module btn_cond #(
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  logic btn_meta, btn_sync, level, level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      btn_meta <= btn;
      btn_sync <= btn_meta;
    end
  end

`ifdef BTN_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  logic [CW-1:0] cnt;

  // Down-counter reloads whenever the level drops; terminal count means stable high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt <= CW'(DEBOUNCE_CYC);
    else if (!btn_sync)      cnt <= CW'(DEBOUNCE_CYC);
    else if (cnt != '0)      cnt <= cnt - 1'b1;
  end

  assign level = btn_sync && (cnt == '0);
`else
  assign level = btn_sync;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      level_q <= level;
      pulse   <= level & ~level_q;
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Loads A, B and opcode from switches on button presses, runs one ALU evaluation, shows result.
// Optional button debounce is enabled by defining BTN_DEBOUNCE_EN.
//
// state   | meaning
// IDLE    | nothing loaded, mask 000
// COLLECT | gathering fields, mask partially set
// EXEC    | one cycle, operands stable, result captured at end
// SHOW    | o_valid high, o_leds holds result
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int NB_DATA      = 4,
  parameter int NB_OP        = 6,
  parameter int NB_SW        = 8,
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic [NB_SW-1:0]   i_sw,
  input  logic               i_btn_a,
  input  logic               i_btn_b,
  input  logic               i_btn_op,
  output logic [NB_DATA-1:0] o_datoA,
  output logic [NB_DATA-1:0] o_datoB,
  output logic [NB_OP-1:0]   o_operation,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_leds,
  output logic               o_valid,
  output logic               o_err
);

  localparam int NB_SYNC = (NB_DATA > NB_OP) ? NB_DATA : NB_OP;

  logic rst_meta, rst_n;
  logic [NB_SYNC-1:0] sw_meta, sw_sync;
  logic pa, pb, pop;

  state_t state_q, state_d;
  logic [2:0] mask_q, mask_d;
  logic [NB_DATA-1:0] a_q, a_d, b_q, b_d, leds_q, leds_d;
  logic [NB_OP-1:0] op_q, op_d;
  logic valid_q, valid_d, err_q, err_d;
  logic op_ok, take_a, take_b, take_op, bad_op;
  logic [2:0] sel;

  // Reset asserts asynchronously, releases synchronously.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rst_meta <= 1'b0;
      rst_n    <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_n    <= rst_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= i_sw[NB_SYNC-1:0];
      sw_sync <= sw_meta;
    end
  end

  btn_cond #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn_a  (.clk(clk), .rst_n(rst_n), .btn(i_btn_a),  .pulse(pa));
  btn_cond #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn_b  (.clk(clk), .rst_n(rst_n), .btn(i_btn_b),  .pulse(pb));
  btn_cond #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn_op (.clk(clk), .rst_n(rst_n), .btn(i_btn_op), .pulse(pop));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mask_q  <= 3'b000;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      leds_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      leds_q  <= leds_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Priority A > B > OP; lower-priority pulses in the same cycle are dropped.
  always_comb begin
    op_ok   = is_legal_op(6'(sw_sync[NB_OP-1:0]));
    take_a  = pa;
    take_b  = pb & ~pa;
    take_op = pop & ~pa & ~pb & op_ok;
    bad_op  = pop & ~pa & ~pb & ~op_ok;
    sel     = {take_op, take_b, take_a};
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    leds_d  = leds_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE, ST_COLLECT, ST_SHOW: begin
        if (bad_op) begin
          err_d = 1'b1;
        end else if (sel != 3'b000) begin
          // A press after a shown result starts a fresh collection.
          mask_d  = ((state_q == ST_SHOW) ? 3'b000 : mask_q) | sel;
          valid_d = 1'b0;
          if (take_a)  a_d  = sw_sync[NB_DATA-1:0];
          if (take_b)  b_d  = sw_sync[NB_DATA-1:0];
          if (take_op) op_d = sw_sync[NB_OP-1:0];
          state_d = (mask_d == 3'b111) ? ST_EXEC : ST_COLLECT;
        end
      end
      ST_EXEC: begin
        leds_d  = i_alu_result;
        valid_d = 1'b1;
        state_d = ST_SHOW;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_datoA     = a_q;
  assign o_datoB     = b_q;
  assign o_operation = op_q;
  assign o_leds      = leds_q;
  assign o_valid     = valid_q;
  assign o_err       = err_q;

endmodule
